hwpe_stream_sink_strided: RTL and testbench
===========================================

// Module: hwpe_stream_sink_strided
// PURPOSE
// - Strided 2D TCDM write sink. One NB_TCDM_PORTS*32-bit stream beat goes out as one word per TCDM port.
// - Addresses: base + line*stride + word*(NB_TCDM_PORTS*4).
// - Each TCDM port is granted independently; a beat retires only when every enabled port is granted.
// - Sits at the HWPE streamer output, between the engine datapath and the TCDM interconnect.
// PARAMETERS
// - NB_TCDM_PORTS  4   number of 32-bit TCDM master ports; stream width = NB_TCDM_PORTS*32
// - ADDR_WIDTH     32  TCDM byte-address width
// - CNT_WIDTH      16  width of the word and line counters
// PORTS
// - clk_i           in   1              clock
// - rst_ni          in   1              reset, asynchronous, active-low
// - clear_i         in   1              synchronous soft clear
// - start_i         in   1              start job; sampled only in IDLE
// - base_addr_i     in   ADDR_WIDTH     first byte address, word aligned
// - line_words_i    in   CNT_WIDTH      beats per line
// - line_stride_i   in   ADDR_WIDTH     byte distance between line starts
// - nb_lines_i      in   CNT_WIDTH      number of lines
// - ready_start_o   out  1              high in IDLE
// - busy_o          out  1              high in WORKING
// - done_o          out  1              1-cycle pulse at job end
// - stall_cnt_o     out  32             TCDM stall cycles (see CONFIGURATION)
// - stream_valid_i  in   1              input beat valid
// - stream_ready_o  out  1              input beat ready
// - stream_data_i   in   NB*32          beat data
// - stream_strb_i   in   NB*4           byte enables
// - tcdm_req_o      out  NB             per-port request
// - tcdm_gnt_i      in   NB             per-port grant
// - tcdm_add_o      out  NB*ADDR_WIDTH  port i address = beat addr + 4*i
// - tcdm_wen_o      out  NB             always 0 (write)
// - tcdm_be_o       out  NB*4           port byte enables
// - tcdm_data_o     out  NB*32          port write data
// BEHAVIOUR
// - Reset: state=IDLE; all counters 0; pending=0; output register empty.
//   Outputs after reset: ready_start_o=1, busy_o=0, done_o=0, stream_ready_o=0, tcdm_req_o=0, tcdm_wen_o=0.
//   tcdm_add_o/be_o/data_o are 0 at reset; afterwards they hold the last beat.
// - FSM IDLE->WORKING on start_i: latches all config and clears counters.
//   If line_words_i==0 or nb_lines_i==0: no transfer, done_o pulses the next cycle, FSM stays IDLE.
// - Accept rule (WORKING): stream_ready_o = accepted<total & (reg empty | reg retiring this cycle).
//   total = line_words*nb_lines. Beats beyond total are never accepted.
// - Latency: a beat accepted at cycle t is presented with tcdm_req at t+1. All outputs are registered.
//   Peak throughput is 1 beat/cycle when grants are immediate.
// - On accept: pending[i] = |strb[4i+3:4i]. A port with an all-zero strobe is never requested.
//   A beat with all-zero strobes retires in its first registered cycle.
// - tcdm_req_o[i] = pending[i]. A grant clears pending[i]. Data, address and be stay stable while any bit is pending.
// - Retire = (pending & ~gnt) == 0. A retire and a new accept in the same cycle is legal (back-to-back).
// - Address counters advance on accept:
//   - word++; when word==line_words-1, word wraps to 0 and line++.
//   - beat addr = base + line*stride + word*NB*4, computed modulo 2^ADDR_WIDTH; wrap-around is silent.
// - Job end: last beat retires -> WORKING->IDLE, done_o=1 for one cycle, ready_start_o=1 from the next cycle.
// - start_i in WORKING is ignored.
// - clear_i (any state) -> IDLE next cycle: pending dropped, requests deasserted, counters zeroed, no done_o.
//   A beat that was granted but not fully retired is lost; the job must be restarted.
// - Reset mid-job behaves like clear_i, asynchronously.
// CONFIGURATION
// - HWPE_STREAM_SINK_STALL_CNT_EN defined: stall_cnt_o increments on every cycle with |(tcdm_req_o & ~tcdm_gnt_i).
//   It is zeroed on start accept, on clear_i and on reset, and saturates at 2^32-1.
// - Not defined: stall_cnt_o is tied to 0 and the counter logic is removed.
// TESTING
// - NB=4, base=0x100, line_words=2, nb_lines=3, stride=0x40, grants always high.
//   Required: addresses 0x100,0x110,0x140,0x150,0x180,0x190; done_o pulses once, 1 cycle after the 6th grant.
// - Port 2 grant delayed 3 cycles on beat 0: stream_ready_o low until the retire; beat 1 is presented the cycle after.
//   Ports 0, 1 and 3 are not re-requested.
// - strb=16'h00F0 on a beat: only tcdm_req_o[1] asserts, with be=4'hF.
//   strb=0 on a beat: no request, and the counters still advance.
// - line_words=0: done_o pulses 1 cycle after start_i; no tcdm_req_o; stream_ready_o stays 0.
// - clear_i asserted while port 0 is pending: tcdm_req_o=0 next cycle, ready_start_o=1, no done_o.
//   Next job starts clean at its base address.
// - STALL_CNT_EN: 5 cycles with gnt=0 on a pending request -> stall_cnt_o=5. Without the macro it stays 0.

Source files
------------

// File: rtl/hwpe_stream_sink_strided_if.sv
// Stream-in / TCDM-out bundle of the strided sink. The slave modport is the sink side
// (it consumes the stream and drives TCDM); the master modport is the environment side.
interface hwpe_stream_sink_strided_if #(
  parameter int unsigned NB_TCDM_PORTS = 4,
  parameter int unsigned ADDR_WIDTH    = 32
) ();
  logic                                stream_valid;
  logic                                stream_ready;
  logic [NB_TCDM_PORTS*32-1:0]         stream_data;
  logic [NB_TCDM_PORTS*4-1:0]          stream_strb;
  logic [NB_TCDM_PORTS-1:0]            tcdm_req;
  logic [NB_TCDM_PORTS-1:0]            tcdm_gnt;
  logic [NB_TCDM_PORTS*ADDR_WIDTH-1:0] tcdm_add;
  logic [NB_TCDM_PORTS-1:0]            tcdm_wen;
  logic [NB_TCDM_PORTS*4-1:0]          tcdm_be;
  logic [NB_TCDM_PORTS*32-1:0]         tcdm_data;

  modport slave (
    input  stream_valid, stream_data, stream_strb, tcdm_gnt,
    output stream_ready, tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
  );

  modport master (
    output stream_valid, stream_data, stream_strb, tcdm_gnt,
    input  stream_ready, tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
  );
endinterface

// File: rtl/hwpe_stream_sink_strided.sv
// Strided 2D TCDM write sink: each stream beat is split into one word per TCDM port.
// Optional stall counter enabled by defining HWPE_STREAM_SINK_STALL_CNT_EN.
module hwpe_stream_sink_strided #(
  parameter int unsigned NB_TCDM_PORTS = 4,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  line_words_i,
  input  logic [ADDR_WIDTH-1:0] line_stride_i,
  input  logic [CNT_WIDTH-1:0]  nb_lines_i,
  output logic                  ready_start_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           stall_cnt_o,
  hwpe_stream_sink_strided_if.slave bus
);

  localparam int unsigned NB    = NB_TCDM_PORTS;
  localparam int unsigned TOT_W = 2 * CNT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(NB_TCDM_PORTS * 4);

  typedef enum logic {IDLE, WORKING} state_e;

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   start_job;

  logic [CNT_WIDTH-1:0]  line_words_q, word_q;
  logic [TOT_W-1:0]      total_q, accepted_q;
  logic [ADDR_WIDTH-1:0] stride_q, line_base_q, word_off_q;

  // Output register: one beat held until every enabled port is granted.
  logic                     reg_valid_q;
  logic [NB-1:0]            pending_q;
  logic [NB*32-1:0]         data_q;
  logic [NB*4-1:0]          be_q;
  logic [NB*ADDR_WIDTH-1:0] add_q;

  logic                     empty_job, retire, accept, last_retire, stream_ready;
  logic [ADDR_WIDTH-1:0]    beat_addr;
  logic [NB*ADDR_WIDTH-1:0] port_add;
  logic [NB-1:0]            port_mask;

  assign empty_job    = (line_words_i == '0) || (nb_lines_i == '0);
  assign retire       = reg_valid_q && ((pending_q & ~bus.tcdm_gnt) == '0);
  assign stream_ready = (state_q == WORKING) && (accepted_q < total_q) && (!reg_valid_q || retire);
  assign accept       = stream_ready && bus.stream_valid;
  assign last_retire  = (state_q == WORKING) && retire && (accepted_q == total_q);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    beat_addr = line_base_q + word_off_q;
    port_add  = '0;
    port_mask = '0;
    for (int i = 0; i < NB; i++) begin
      port_add[i*ADDR_WIDTH +: ADDR_WIDTH] = beat_addr + ADDR_WIDTH'(4 * i);
      port_mask[i] = |bus.stream_strb[4*i +: 4];
    end
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    start_job = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            start_job = 1'b1;
            if (empty_job) done_d  = 1'b1;
            else           state_d = WORKING;
          end
        end
        WORKING: begin
          if (last_retire) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_words_q <= '0;
      word_q       <= '0;
      total_q      <= '0;
      accepted_q   <= '0;
      stride_q     <= '0;
      line_base_q  <= '0;
      word_off_q   <= '0;
      reg_valid_q  <= 1'b0;
      pending_q    <= '0;
      data_q       <= '0;
      be_q         <= '0;
      add_q        <= '0;
    end else if (clear_i) begin
      word_q      <= '0;
      total_q     <= '0;
      accepted_q  <= '0;
      line_base_q <= '0;
      word_off_q  <= '0;
      reg_valid_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      if (start_job) begin
        line_words_q <= line_words_i;
        stride_q     <= line_stride_i;
        total_q      <= TOT_W'(line_words_i) * TOT_W'(nb_lines_i);
        line_base_q  <= base_addr_i;
        word_q       <= '0;
        word_off_q   <= '0;
        accepted_q   <= '0;
      end
      pending_q <= pending_q & ~bus.tcdm_gnt;
      if (retire) reg_valid_q <= 1'b0;
      if (accept) begin
        reg_valid_q <= 1'b1;
        pending_q   <= port_mask;
        data_q      <= bus.stream_data;
        be_q        <= bus.stream_strb;
        add_q       <= port_add;
        accepted_q  <= accepted_q + TOT_W'(1);
        // Line base advances by the stride; the in-line offset steps by one beat width.
        if (word_q == line_words_q - CNT_WIDTH'(1)) begin
          word_q      <= '0;
          word_off_q  <= '0;
          line_base_q <= line_base_q + stride_q;
        end else begin
          word_q     <= word_q + CNT_WIDTH'(1);
          word_off_q <= word_off_q + BEAT_BYTES;
        end
      end
    end
  end

`ifdef HWPE_STREAM_SINK_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (clear_i || start_job) begin
      stall_cnt_q <= '0;
    end else if ((|(pending_q & ~bus.tcdm_gnt)) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign ready_start_o    = (state_q == IDLE);
  assign busy_o           = (state_q == WORKING);
  assign done_o           = done_q;
  assign bus.stream_ready = stream_ready;
  assign bus.tcdm_req     = pending_q;
  assign bus.tcdm_wen     = '0;
  assign bus.tcdm_add     = add_q;
  assign bus.tcdm_be      = be_q;
  assign bus.tcdm_data    = data_q;

endmodule

// File: tb/tb_hwpe_stream_sink_strided.sv
// Bench for hwpe_stream_sink_strided: directed scenarios plus randomized jobs, all checked
// every cycle against a transaction-level model of the strided write sink.
module tb_hwpe_stream_sink_strided;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int CW = 16;
`ifdef HWPE_STREAM_SINK_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] stride = '0;
  logic [CW-1:0] lw = '0;
  logic [CW-1:0] nl = '0;
  logic          ready_start, busy, done;
  logic [31:0]   stall_cnt;

  always #5 clk = ~clk;

  hwpe_stream_sink_strided_if #(.NB_TCDM_PORTS(NB), .ADDR_WIDTH(AW)) bus ();

  hwpe_stream_sink_strided #(.NB_TCDM_PORTS(NB), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .start_i       (start),
    .base_addr_i   (base),
    .line_words_i  (lw),
    .line_stride_i (stride),
    .nb_lines_i    (nl),
    .ready_start_o (ready_start),
    .busy_o        (busy),
    .done_o        (done),
    .stall_cnt_o   (stall_cnt),
    .bus           (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream source and grant generator.
  typedef struct {
    logic [127:0] data;
    logic [15:0]  strb;
  } beat_t;

  beat_t src_q[$];
  bit    rand_valid = 1'b0;
  int    gnt_mode = 0;  // 0: always granted, 1: random, 2: driven by the main sequence
  bit    hs;

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [15:0] rand_strb();
    logic [15:0] s = '0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0:       s[4*i +: 4] = 4'h0;
        1:       s[4*i +: 4] = 4'($urandom);
        default: s[4*i +: 4] = 4'hF;
      endcase
    end
    return s;
  endfunction

  always begin
    @(negedge clk);
    hs = bus.stream_valid && bus.stream_ready;
    @(posedge clk);
    #1;
    if (hs && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0 && (bus.stream_valid || !rand_valid || $urandom_range(0, 1) == 1)) begin
      bus.stream_valid = 1'b1;
      bus.stream_data  = src_q[0].data;
      bus.stream_strb  = src_q[0].strb;
    end else begin
      bus.stream_valid = 1'b0;
    end
    if (gnt_mode == 0) bus.tcdm_gnt = '1;
    else if (gnt_mode == 1) begin
      for (int i = 0; i < NB; i++) bus.tcdm_gnt[i] = ($urandom_range(0, 3) != 0);
    end
  end

  // Transaction-level reference: beat k of a job goes to base + (k/lw)*stride + (k%lw)*16.
  bit           chk_en = 1'b0;
  bit           m_busy = 1'b0, m_done = 1'b0, m_has = 1'b0, m_any = 1'b0;
  logic [3:0]   m_rem = '0;
  int           m_acc = 0, m_total = 0, m_lw = 0;
  logic [31:0]  m_base = '0, m_stride = '0, m_addr = '0;
  logic [127:0] m_data = '0;
  logic [15:0]  m_strb = '0;
  longint       m_stall = 0;
  logic [3:0]   req_exp, gnt_s;
  bit           rdy_exp, retiring, done_n;
  logic [127:0] add_exp;

  always begin
    @(negedge clk);
    req_exp = m_has ? m_rem : 4'h0;
    rdy_exp = m_busy && (m_acc < m_total) && (!m_has || ((m_rem & ~bus.tcdm_gnt) == 4'h0));
    add_exp = '0;
    if (m_any) for (int i = 0; i < NB; i++) add_exp[32*i +: 32] = m_addr + 32'(4 * i);
    if (chk_en) begin
      check("ready_start", ready_start, !m_busy);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("stream_ready", bus.stream_ready, rdy_exp);
      check("tcdm_req", bus.tcdm_req, req_exp);
      check("tcdm_wen", bus.tcdm_wen, 4'h0);
      check("tcdm_add", bus.tcdm_add, add_exp);
      check("tcdm_be", bus.tcdm_be, m_strb);
      check("tcdm_data", bus.tcdm_data, m_data);
      check("stall_cnt", stall_cnt, STALL_EN ? 32'(m_stall) : 32'h0);
    end
    @(posedge clk);
    if (rst_n) begin
      gnt_s  = bus.tcdm_gnt;
      done_n = 1'b0;
      if (|(req_exp & ~gnt_s)) m_stall++;
      if (clear) begin
        m_busy = 1'b0; m_has = 1'b0; m_rem = '0; m_acc = 0; m_stall = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_stall = 0; m_acc = 0; m_lw = int'(lw); m_total = int'(lw) * int'(nl);
          m_base = base; m_stride = stride;
          if (m_total == 0) done_n = 1'b1;
          else              m_busy = 1'b1;
        end
      end else begin
        retiring = m_has && ((m_rem & ~gnt_s) == 4'h0);
        m_rem = m_rem & ~gnt_s;
        if (retiring) m_has = 1'b0;
        if (rdy_exp && bus.stream_valid) begin
          m_addr = m_base + m_stride * 32'(m_acc / m_lw) + 32'((m_acc % m_lw) * NB * 4);
          m_data = bus.stream_data;
          m_strb = bus.stream_strb;
          for (int i = 0; i < NB; i++) m_rem[i] = |bus.stream_strb[4*i +: 4];
          m_has = 1'b1;
          m_any = 1'b1;
          m_acc++;
        end else if (retiring && m_acc == m_total) begin
          m_busy = 1'b0;
          done_n = 1'b1;
        end
      end
      m_done = done_n;
    end
  end

  task automatic start_job(input logic [31:0] b, input int w, input int n, input logic [31:0] s);
    @(posedge clk); #1;
    base = b; lw = CW'(w); nl = CW'(n); stride = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check(name, seen, 1'b1);
    if (!seen) pulse_clear();
  endtask

  task automatic wait_req(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.tcdm_req != '0);
    end
    check(name, seen, 1'b1);
  endtask

  task automatic set_gnt(input int mode, input logic [3:0] g);
    @(posedge clk); #2;
    gnt_mode = mode;
    bus.tcdm_gnt = g;
  endtask

  logic [31:0] addr_log[$];
  logic [31:0] t1_exp[6];
  int          dcnt, dcyc, last_g;

  initial begin
    bus.stream_valid = 1'b0;
    bus.stream_data  = '0;
    bus.stream_strb  = '0;
    bus.tcdm_gnt     = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_start", ready_start, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stream_ready", bus.stream_ready, 1'b0);
    check("rst_req", bus.tcdm_req, 4'h0);
    check("rst_wen", bus.tcdm_wen, 4'h0);
    check("rst_add", bus.tcdm_add, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Basic 2x3 job with immediate grants.
    t1_exp = '{32'h100, 32'h110, 32'h140, 32'h150, 32'h180, 32'h190};
    for (int i = 0; i < 6; i++) src_q.push_back('{rand_data(), 16'hFFFF});
    dcnt = 0; dcyc = -1; last_g = -100;
    start_job(32'h100, 2, 3, 32'h40);
    repeat (20) begin
      @(negedge clk);
      if (bus.tcdm_req[0]) addr_log.push_back(bus.tcdm_add[31:0]);
      if (bus.tcdm_req != '0 && (bus.tcdm_req & ~bus.tcdm_gnt) == '0) last_g = cyc;
      if (done) begin dcnt++; dcyc = cyc; end
    end
    check("t1_addr_count", addr_log.size(), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++) check("t1_addr", addr_log[i], t1_exp[i]);
    check("t1_done_count", dcnt, 1);
    check("t1_done_latency", dcyc, last_g + 1);

    // Port 2 grant held off for three cycles on beat 0.
    set_gnt(2, 4'b1011);
    for (int i = 0; i < 2; i++) src_q.push_back('{rand_data(), 16'hFFFF});
    start_job(32'h200, 2, 1, 32'h0);
    wait_req("t2_req_seen");
    check("t2_req_first", bus.tcdm_req, 4'hF);
    check("t2_addr_first", bus.tcdm_add[31:0], 32'h200);
    check("t2_ready_first", bus.stream_ready, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("t2_req_hold", bus.tcdm_req, 4'b0100);
      check("t2_ready_hold", bus.stream_ready, 1'b0);
    end
    set_gnt(2, 4'hF);
    @(negedge clk);
    check("t2_req_last", bus.tcdm_req, 4'b0100);
    check("t2_ready_retire", bus.stream_ready, 1'b1);
    @(negedge clk);
    check("t2_beat1_req", bus.tcdm_req, 4'hF);
    check("t2_beat1_addr", bus.tcdm_add[31:0], 32'h210);
    set_gnt(0, 4'hF);
    wait_done("t2_done", 50);

    // Partial and empty strobes.
    src_q.push_back('{rand_data(), 16'h00F0});
    src_q.push_back('{rand_data(), 16'h0000});
    start_job(32'h300, 2, 1, 32'h0);
    wait_req("t3_req_seen");
    check("t3_req_port1", bus.tcdm_req, 4'b0010);
    check("t3_be_port1", bus.tcdm_be[7:4], 4'hF);
    @(negedge clk);
    check("t3_zero_strb_req", bus.tcdm_req, 4'h0);
    check("t3_zero_strb_addr", bus.tcdm_add[31:0], 32'h310);
    @(negedge clk);
    check("t3_done", done, 1'b1);

    // Zero-length job: done next cycle, stream never accepted.
    src_q.push_back('{rand_data(), 16'hFFFF});
    start_job(32'h400, 0, 5, 32'h0);
    @(negedge clk);
    check("t4_done", done, 1'b1);
    check("t4_busy", busy, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("t4_no_done", done, 1'b0);
      check("t4_no_ready", bus.stream_ready, 1'b0);
      check("t4_no_req", bus.tcdm_req, 4'h0);
    end
    src_q.delete();

    // Clear while port 0 is pending, then a clean job.
    set_gnt(2, 4'h0);
    for (int i = 0; i < 4; i++) src_q.push_back('{rand_data(), 16'hFFFF});
    start_job(32'h500, 2, 2, 32'h20);
    wait_req("t5_req_seen");
    check("t5_port0_pending", bus.tcdm_req[0], 1'b1);
    @(posedge clk); #1; clear = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    check("t5_req_cleared", bus.tcdm_req, 4'h0);
    check("t5_ready_start", ready_start, 1'b1);
    check("t5_no_done", done, 1'b0);
    src_q.delete();
    set_gnt(0, 4'hF);
    src_q.push_back('{rand_data(), 16'hFFFF});
    start_job(32'h600, 1, 1, 32'h0);
    wait_req("t5_next_req_seen");
    check("t5_next_addr", bus.tcdm_add[31:0], 32'h600);
    wait_done("t5_next_done", 50);

    // Five stalled cycles on a pending request.
    set_gnt(2, 4'h0);
    src_q.push_back('{rand_data(), 16'hFFFF});
    start_job(32'h700, 1, 1, 32'h0);
    wait_req("t6_req_seen");
    check("t6_stall_start", stall_cnt, 32'h0);
    repeat (5) @(negedge clk);
    check("t6_stall_five", stall_cnt, STALL_EN ? 32'd5 : 32'd0);
    set_gnt(0, 4'hF);
    wait_done("t6_done", 50);

    // Randomized jobs, including address wrap and a mid-job clear.
    for (int r = 0; r < 14; r++) begin
      int w, n;
      logic [31:0] b, s;
      w = $urandom_range(0, 4);
      n = $urandom_range(0, 3);
      b = (r == 3) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFFC);
      s = $urandom & 32'hFFFF_FFFC;
      rand_valid = ($urandom_range(0, 1) == 1);
      set_gnt(($urandom_range(0, 2) == 0) ? 0 : 1, 4'hF);
      for (int i = 0; i < w * n + 2; i++) src_q.push_back('{rand_data(), rand_strb()});
      start_job(b, w, n, s);
      if (r == 5 && w * n > 0) begin
        repeat ($urandom_range(2, 8)) @(negedge clk);
        pulse_clear();
      end else begin
        wait_done("rand_done", 500);
      end
      repeat (2) @(negedge clk);
      src_q.delete();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
